axi_slave_regfile: RTL and testbench
====================================

AXI_SLAVE_REGFILE -- requirements
Module: axi_slave_regfile

Interface
REQ-001 SHALL have parameter S_ID, default 4: slave-side ID width, equal to master ID width plus master-select width.
REQ-002 SHALL have parameter REG_NUM, default 16: number of 32-bit registers; a power of 2, minimum 2.
REQ-003 SHALL have port BUS_CLK  in  1: the single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port BUS_RST  in  1: reset, asynchronous and active-high.
REQ-005 SHALL have write-address ports: WR_ADDR_ID in S_ID; WR_ADDR in 32 (byte offset already translated by the interconnect); WR_ADDR_LEN in 8 (beats-1); WR_ADDR_BURST in 2; WR_ADDR_VALID in 1; WR_ADDR_READY out 1.
REQ-006 SHALL have write-data ports: WR_DATA in 32; WR_STRB in 4; WR_DATA_LAST in 1; WR_DATA_VALID in 1; WR_DATA_READY out 1.
REQ-007 SHALL have write-response ports: WR_BACK_ID out S_ID; WR_BACK_RESP out 2; WR_BACK_VALID out 1; WR_BACK_READY in 1.
REQ-008 SHALL have read-address ports: RD_ADDR_ID in S_ID; RD_ADDR in 32; RD_ADDR_LEN in 8; RD_ADDR_BURST in 2; RD_ADDR_VALID in 1; RD_ADDR_READY out 1.
REQ-009 SHALL have read-data ports: RD_BACK_ID out S_ID; RD_DATA out 32; RD_DATA_RESP out 2; RD_DATA_LAST out 1; RD_DATA_VALID out 1; RD_DATA_READY in 1.
REQ-010 SHALL have port REG_OUT  out  REG_NUM*32: flat view of all registers, register i at bits [32i+31:32i].

Function
REQ-011 SHALL run the write channel on an FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE, and the read channel on an independent FSM R_IDLE -> R_DATA -> R_IDLE.
REQ-012 SHALL assert WR_ADDR_READY only in W_IDLE and RD_ADDR_READY only in R_IDLE, and hold both low while BUS_RST is high.
REQ-013 SHALL, on the AW handshake, latch ID, word index (ADDR[log2(REG_NUM)+1:2]), BURST and an out-of-range flag (any ADDR bit above the index field set, or ADDR[1:0] nonzero), then enter W_DATA.
REQ-014 SHALL hold WR_DATA_READY high in W_DATA; each accepted beat writes byte k of the indexed register when STRB[k]=1, unless the out-of-range flag is set.
REQ-015 SHALL advance the beat index per accepted beat: BURST 2'b00 (FIXED) unchanged; 2'b01 (INCR) and 2'b10/2'b11 +1 modulo REG_NUM (wrap-around, no error).
REQ-016 SHALL end W_DATA on the beat accepted with WR_DATA_LAST=1, regardless of beat count versus LEN; that beat's write still commits.
REQ-017 SHALL, in W_RESP, drive WR_BACK_VALID=1 with the latched ID and RESP 2'b00 (OKAY), or 2'b10 (SLVERR) when out-of-range, held stable until WR_BACK_READY; return to W_IDLE on the cycle after the handshake.
REQ-018 SHALL, on the AR handshake, latch ID, index, BURST, LEN and the out-of-range flag, and present the first beat registered one cycle later (RD_DATA_VALID=1).
REQ-019 SHALL hold RD_DATA, RD_BACK_ID, RD_DATA_RESP and RD_DATA_LAST stable while RD_DATA_VALID=1 and RD_DATA_READY=0.
REQ-020 SHALL allow back-to-back beats at one beat per cycle when RD_DATA_READY=1, advancing the index as in REQ-015.
REQ-021 SHALL assert RD_DATA_LAST on beat LEN (0-based), and return to R_IDLE after that beat's handshake.
REQ-022 SHALL, for an out-of-range read, return RD_DATA=0 with RESP 2'b10 on every beat.
REQ-023 SHALL, on a same-cycle write commit and read-beat load of one register, return the pre-write value for that beat.
REQ-024 SHALL update REG_OUT in the cycle after the write commit.

Reset
REQ-025 SHALL, while BUS_RST=1, force both FSMs to IDLE, all registers to 0, and every VALID, READY and LAST output, RD_DATA, RESP and ID outputs to 0.
REQ-026 SHALL abort any transaction in flight when BUS_RST asserts mid-burst: no response is issued, and partially written registers are cleared.

Structure
REQ-027 SHALL take burst codes (FIXED/INCR/WRAP), response codes (OKAY/SLVERR) and the FSM state enums from the shared package axi_pkg.
REQ-028 SHALL use one sub-module, axi_burst_index, which computes the next index from index, burst and REG_NUM, and is instantiated once per channel.

Verification
REQ-029 SHALL verify a single write: AW addr 0x08, LEN 0, data 0xA5A5A5A5, STRB 4'hF -> BACK RESP 00 with the same ID, and REG_OUT[2]=0xA5A5A5A5.
REQ-030 SHALL verify an INCR wrap: write 4 beats from addr 0x38 (REG_NUM 16) with data 1,2,3,4 -> regs 14,15,0,1 = 1,2,3,4.
REQ-031 SHALL verify a FIXED read with backpressure: read 3 beats at addr 0x04, RD_DATA_READY toggling 1/0 -> three identical beats, LAST only on the third, outputs stable while stalled.
REQ-032 SHALL verify an out-of-range access: write/read at addr 0x100 -> RESP 10, no register changes, read data 0.
REQ-033 SHALL verify a partial strobe: reg 3 = 0x11223344, write 0xAABBCCDD with STRB 4'b0101 -> reg 3 = 0x11BB33DD.
REQ-034 SHALL verify reset mid-burst: assert BUS_RST during beat 2 of a 4-beat write -> all outputs 0, all registers 0, and the next AW is accepted normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI codes and channel FSM states for the slave register file.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi_burst_index.sv
// Next word index for a burst beat; non-FIXED bursts wrap modulo REG_NUM.
module axi_burst_index #(
    parameter int REG_NUM = 16,
    parameter int IDXW    = $clog2(REG_NUM)
) (
    input  logic [IDXW-1:0] idx_i,
    input  logic [1:0]      burst_i,
    output logic [IDXW-1:0] idx_o
);
    import axi_pkg::*;

    // Index width equals log2(REG_NUM), so the add wraps for free.
    always_comb begin
        idx_o = idx_i;
        if (burst_i != BURST_FIXED) begin
            idx_o = idx_i + IDXW'(1);
        end
    end

endmodule

// File: rtl/axi_slave_regfile.sv
// AXI slave exposing REG_NUM 32-bit registers with independent
// write (AW/W/B) and read (AR/R) channel FSMs.
module axi_slave_regfile #(
    parameter int S_ID    = 4,
    parameter int REG_NUM = 16
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic [S_ID-1:0]       WR_ADDR_ID,
    input  logic [31:0]           WR_ADDR,
    input  logic [7:0]            WR_ADDR_LEN,
    input  logic [1:0]            WR_ADDR_BURST,
    input  logic                  WR_ADDR_VALID,
    output logic                  WR_ADDR_READY,
    input  logic [31:0]           WR_DATA,
    input  logic [3:0]            WR_STRB,
    input  logic                  WR_DATA_LAST,
    input  logic                  WR_DATA_VALID,
    output logic                  WR_DATA_READY,
    output logic [S_ID-1:0]       WR_BACK_ID,
    output logic [1:0]            WR_BACK_RESP,
    output logic                  WR_BACK_VALID,
    input  logic                  WR_BACK_READY,
    input  logic [S_ID-1:0]       RD_ADDR_ID,
    input  logic [31:0]           RD_ADDR,
    input  logic [7:0]            RD_ADDR_LEN,
    input  logic [1:0]            RD_ADDR_BURST,
    input  logic                  RD_ADDR_VALID,
    output logic                  RD_ADDR_READY,
    output logic [S_ID-1:0]       RD_BACK_ID,
    output logic [31:0]           RD_DATA,
    output logic [1:0]            RD_DATA_RESP,
    output logic                  RD_DATA_LAST,
    output logic                  RD_DATA_VALID,
    input  logic                  RD_DATA_READY,
    output logic [REG_NUM*32-1:0] REG_OUT
);
    import axi_pkg::*;

    localparam int IDXW = $clog2(REG_NUM);

    function automatic logic addr_oor(input logic [31:0] a);
        addr_oor = (a[1:0] != 2'b00) || ((a >> (IDXW + 2)) != 32'd0);
    endfunction

    logic [31:0] regs_q [REG_NUM];

    // Write termination follows WLAST, so AWLEN carries no information.
    logic unused_wlen;
    assign unused_wlen = ^WR_ADDR_LEN;

    w_state_e        w_state_q, w_state_d;
    logic [S_ID-1:0] wr_id_q, wr_id_d;
    logic [IDXW-1:0] wr_idx_q, wr_idx_d, wr_idx_nxt;
    logic [1:0]      wr_burst_q, wr_burst_d;
    logic            wr_oor_q, wr_oor_d;
    logic            aw_hs, w_hs, b_hs, wr_commit;

    assign WR_ADDR_READY = !BUS_RST && (w_state_q == W_IDLE);
    assign WR_DATA_READY = !BUS_RST && (w_state_q == W_DATA);
    assign WR_BACK_VALID = !BUS_RST && (w_state_q == W_RESP);
    assign WR_BACK_ID    = WR_BACK_VALID ? wr_id_q : '0;
    assign WR_BACK_RESP  = !WR_BACK_VALID ? RESP_OKAY :
                           wr_oor_q ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs     = WR_ADDR_VALID && WR_ADDR_READY;
    assign w_hs      = WR_DATA_VALID && WR_DATA_READY;
    assign b_hs      = WR_BACK_VALID && WR_BACK_READY;
    assign wr_commit = w_hs && !wr_oor_q;

    axi_burst_index #(
        .REG_NUM (REG_NUM),
        .IDXW    (IDXW)
    ) u_wr_idx (
        .idx_i   (wr_idx_q),
        .burst_i (wr_burst_q),
        .idx_o   (wr_idx_nxt)
    );

    always_comb begin
        w_state_d  = w_state_q;
        wr_id_d    = wr_id_q;
        wr_idx_d   = wr_idx_q;
        wr_burst_d = wr_burst_q;
        wr_oor_d   = wr_oor_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    wr_id_d    = WR_ADDR_ID;
                    wr_idx_d   = WR_ADDR[IDXW+1:2];
                    wr_burst_d = WR_ADDR_BURST;
                    wr_oor_d   = addr_oor(WR_ADDR);
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    wr_idx_d = wr_idx_nxt;
                    if (WR_DATA_LAST) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            w_state_q  <= W_IDLE;
            wr_id_q    <= '0;
            wr_idx_q   <= '0;
            wr_burst_q <= '0;
            wr_oor_q   <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            wr_id_q    <= wr_id_d;
            wr_idx_q   <= wr_idx_d;
            wr_burst_q <= wr_burst_d;
            wr_oor_q   <= wr_oor_d;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (WR_STRB[k]) begin
                    regs_q[wr_idx_q][8*k +: 8] <= WR_DATA[8*k +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_reg_out
        assign REG_OUT[32*g +: 32] = regs_q[g];
    end

    r_state_e        r_state_q, r_state_d;
    logic [S_ID-1:0] rd_id_q, rd_id_d;
    logic [IDXW-1:0] rd_idx_q, rd_idx_d, rd_idx_nxt;
    logic [1:0]      rd_burst_q, rd_burst_d;
    logic [7:0]      rd_len_q, rd_len_d;
    logic [7:0]      rd_cnt_q, rd_cnt_d;
    logic            rd_oor_q, rd_oor_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q, rd_last_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic [1:0]      rd_resp_q, rd_resp_d;
    logic            ar_hs, r_hs, ar_oor;

    assign RD_ADDR_READY = !BUS_RST && (r_state_q == R_IDLE);
    assign RD_BACK_ID    = rd_id_q;
    assign RD_DATA       = rd_data_q;
    assign RD_DATA_RESP  = rd_resp_q;
    assign RD_DATA_LAST  = rd_last_q;
    assign RD_DATA_VALID = rd_valid_q;

    assign ar_hs  = RD_ADDR_VALID && RD_ADDR_READY;
    assign r_hs   = rd_valid_q && RD_DATA_READY;
    assign ar_oor = addr_oor(RD_ADDR);

    axi_burst_index #(
        .REG_NUM (REG_NUM),
        .IDXW    (IDXW)
    ) u_rd_idx (
        .idx_i   (rd_idx_q),
        .burst_i (rd_burst_q),
        .idx_o   (rd_idx_nxt)
    );

    // Beats load from regs_q before any same-edge write lands.
    always_comb begin
        r_state_d  = r_state_q;
        rd_id_d    = rd_id_q;
        rd_idx_d   = rd_idx_q;
        rd_burst_d = rd_burst_q;
        rd_len_d   = rd_len_q;
        rd_cnt_d   = rd_cnt_q;
        rd_oor_d   = rd_oor_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_data_d  = rd_data_q;
        rd_resp_d  = rd_resp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_id_d    = RD_ADDR_ID;
                    rd_idx_d   = RD_ADDR[IDXW+1:2];
                    rd_burst_d = RD_ADDR_BURST;
                    rd_len_d   = RD_ADDR_LEN;
                    rd_cnt_d   = 8'd0;
                    rd_oor_d   = ar_oor;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (RD_ADDR_LEN == 8'd0);
                    rd_data_d  = ar_oor ? 32'd0 : regs_q[RD_ADDR[IDXW+1:2]];
                    rd_resp_d  = ar_oor ? RESP_SLVERR : RESP_OKAY;
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rd_last_q) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        r_state_d  = R_IDLE;
                    end else begin
                        rd_idx_d  = rd_idx_nxt;
                        rd_cnt_d  = rd_cnt_q + 8'd1;
                        rd_last_d = ((rd_cnt_q + 8'd1) == rd_len_q);
                        rd_data_d = rd_oor_q ? 32'd0 : regs_q[rd_idx_nxt];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_state_q  <= R_IDLE;
            rd_id_q    <= '0;
            rd_idx_q   <= '0;
            rd_burst_q <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            rd_oor_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_resp_q  <= '0;
        end else begin
            r_state_q  <= r_state_d;
            rd_id_q    <= rd_id_d;
            rd_idx_q   <= rd_idx_d;
            rd_burst_q <= rd_burst_d;
            rd_len_q   <= rd_len_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_oor_q   <= rd_oor_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
            rd_resp_q  <= rd_resp_d;
        end
    end

endmodule

// File: tb/tb_axi_slave_regfile.sv
// Randomized bench for axi_slave_regfile against an array model.
module tb_axi_slave_regfile;

    localparam int S_ID    = 4;
    localparam int REG_NUM = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [S_ID-1:0]       aw_id;
    logic [31:0]           aw_addr;
    logic [7:0]            aw_len;
    logic [1:0]            aw_burst;
    logic                  aw_valid;
    logic                  aw_ready;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic                  w_last;
    logic                  w_valid;
    logic                  w_ready;
    logic [S_ID-1:0]       b_id;
    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;
    logic [S_ID-1:0]       ar_id;
    logic [31:0]           ar_addr;
    logic [7:0]            ar_len;
    logic [1:0]            ar_burst;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [S_ID-1:0]       r_id;
    logic [31:0]           r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_valid;
    logic                  r_ready;
    logic [REG_NUM*32-1:0] reg_out;

    always #5 clk = ~clk;

    axi_slave_regfile #(
        .S_ID    (S_ID),
        .REG_NUM (REG_NUM)
    ) dut (
        .BUS_CLK       (clk),
        .BUS_RST       (rst),
        .WR_ADDR_ID    (aw_id),
        .WR_ADDR       (aw_addr),
        .WR_ADDR_LEN   (aw_len),
        .WR_ADDR_BURST (aw_burst),
        .WR_ADDR_VALID (aw_valid),
        .WR_ADDR_READY (aw_ready),
        .WR_DATA       (w_data),
        .WR_STRB       (w_strb),
        .WR_DATA_LAST  (w_last),
        .WR_DATA_VALID (w_valid),
        .WR_DATA_READY (w_ready),
        .WR_BACK_ID    (b_id),
        .WR_BACK_RESP  (b_resp),
        .WR_BACK_VALID (b_valid),
        .WR_BACK_READY (b_ready),
        .RD_ADDR_ID    (ar_id),
        .RD_ADDR       (ar_addr),
        .RD_ADDR_LEN   (ar_len),
        .RD_ADDR_BURST (ar_burst),
        .RD_ADDR_VALID (ar_valid),
        .RD_ADDR_READY (ar_ready),
        .RD_BACK_ID    (r_id),
        .RD_DATA       (r_data),
        .RD_DATA_RESP  (r_resp),
        .RD_DATA_LAST  (r_last),
        .RD_DATA_VALID (r_valid),
        .RD_DATA_READY (r_ready),
        .REG_OUT       (reg_out)
    );

    int          n_tot = 0;
    int          n_bad = 0;
    logic [31:0] mdl  [REG_NUM];
    logic [31:0] wdat [8];
    logic [3:0]  wstb [8];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
        return (a % 4 != 0) || (a >= REG_NUM * 4);
    endfunction

    function automatic int beat_reg(input logic [31:0] a,
                                    input logic [1:0] burst, input int b);
        int s;
        s = int'(a / 4) % REG_NUM;
        return (burst == 2'b00) ? s : (s + b) % REG_NUM;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < REG_NUM; i++) begin
            chk(tag, 64'(reg_out[32*i +: 32]), 64'(mdl[i]));
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input logic [1:0] burst, input int n);
        int t;
        bit oor;
        int r;
        oor      = is_oor(addr);
        aw_id    = id;
        aw_addr  = addr;
        aw_len   = 8'(n - 1);
        aw_burst = burst;
        aw_valid = 1'b1;
        t = 0;
        while (!aw_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("aw_tmo", 1, 0);
        @(negedge clk);
        aw_valid = 1'b0;
        for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            w_data  = wdat[b];
            w_strb  = wstb[b];
            w_last  = (b == n - 1);
            w_valid = 1'b1;
            t = 0;
            while (!w_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) chk("w_tmo", 1, 0);
            if (!oor) begin
                r = beat_reg(addr, burst, b);
                for (int k = 0; k < 4; k++) begin
                    if (wstb[b][k]) mdl[r][8*k +: 8] = wdat[b][8*k +: 8];
                end
            end
            @(negedge clk);
            w_valid = 1'b0;
            w_last  = 1'b0;
        end
        t = 0;
        while (!b_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("b_tmo", 1, 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("b_valid", 64'(b_valid), 1);
        chk("b_id", 64'(b_id), 64'(id));
        chk("b_resp", 64'(b_resp), oor ? 64'd2 : 64'd0);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        chk("b_drop", 64'(b_valid), 0);
        chk("aw_rdy", 64'(aw_ready), 1);
        check_regs("reg");
    endtask

    // mode: 0 ready always, 1 toggling 1/0, 2 random
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input logic [1:0] burst, input int len,
                           input int mode);
        int t;
        int b;
        int cyc;
        bit oor;
        bit stalled;
        logic [31:0] s_data;
        logic s_last;
        logic [31:0] e_data;
        oor      = is_oor(addr);
        ar_id    = id;
        ar_addr  = addr;
        ar_len   = 8'(len);
        ar_burst = burst;
        ar_valid = 1'b1;
        t = 0;
        while (!ar_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ar_tmo", 1, 0);
        @(negedge clk);
        ar_valid = 1'b0;
        chk("r_lat", 64'(r_valid), 1);
        b = 0;
        cyc = 0;
        stalled = 0;
        s_data = '0;
        s_last = 1'b0;
        while (b <= len && cyc < 200) begin
            if (mode == 0) r_ready = 1'b1;
            else if (mode == 1) r_ready = (cyc % 2 == 0);
            else r_ready = 1'($urandom_range(0, 1));
            if (r_valid) begin
                if (stalled) begin
                    chk("r_hold_d", 64'(r_data), 64'(s_data));
                    chk("r_hold_l", 64'(r_last), 64'(s_last));
                end
                if (r_ready) begin
                    e_data = oor ? 32'd0 : mdl[beat_reg(addr, burst, b)];
                    chk("r_data", 64'(r_data), 64'(e_data));
                    chk("r_last", 64'(r_last), 64'(b == len));
                    chk("r_resp", 64'(r_resp), oor ? 64'd2 : 64'd0);
                    chk("r_id", 64'(r_id), 64'(id));
                    b++;
                    stalled = 0;
                end else begin
                    s_data  = r_data;
                    s_last  = r_last;
                    stalled = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (b <= len) chk("r_tmo", 1, 0);
        r_ready = 1'b0;
        chk("r_end", 64'(r_valid), 0);
        chk("ar_rdy", 64'(ar_ready), 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_awr"}, 64'(aw_ready), 0);
        chk({tag, "_wr"}, 64'(w_ready), 0);
        chk({tag, "_bv"}, 64'({b_valid, b_resp, b_id}), 0);
        chk({tag, "_arr"}, 64'(ar_ready), 0);
        chk({tag, "_rv"}, 64'({r_valid, r_last, r_resp, r_id}), 0);
        chk({tag, "_rd"}, 64'(r_data), 0);
        chk({tag, "_regs"}, 64'(reg_out != '0), 0);
    endtask

    initial begin
        logic [31:0] a;
        int n;
        logic [1:0] bu;
        rst = 1'b1;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = '0; aw_valid = 0;
        w_data = '0; w_strb = '0; w_last = 0; w_valid = 0; b_ready = 0;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = '0; ar_valid = 0;
        r_ready = 0;
        for (int i = 0; i < REG_NUM; i++) mdl[i] = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("rst");
        rst = 1'b0;
        @(negedge clk);

        wdat[0] = 32'hA5A5A5A5; wstb[0] = 4'hF;
        do_write(4'h3, 32'h08, 2'b01, 1);
        chk("single", 64'(reg_out[2*32 +: 32]), 64'h A5A5A5A5);

        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'(i + 1);
            wstb[i] = 4'hF;
        end
        do_write(4'h5, 32'h38, 2'b01, 4);
        chk("wrap14", 64'(reg_out[14*32 +: 32]), 1);
        chk("wrap15", 64'(reg_out[15*32 +: 32]), 2);
        chk("wrap0", 64'(reg_out[0 +: 32]), 3);
        chk("wrap1", 64'(reg_out[32 +: 32]), 4);

        do_read(4'h6, 32'h04, 2'b00, 2, 1);

        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        do_write(4'h7, 32'h100, 2'b01, 1);
        do_read(4'h8, 32'h100, 2'b01, 1, 2);

        wdat[0] = 32'h11223344; wstb[0] = 4'hF;
        do_write(4'h1, 32'h0C, 2'b01, 1);
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
        do_write(4'h2, 32'h0C, 2'b01, 1);
        chk("strb", 64'(reg_out[3*32 +: 32]), 64'h11BB33DD);

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 5) == 0)
                a = ($urandom_range(0, 1) == 1) ? 32'h40 + 32'($urandom_range(0, 255))
                                               : 32'($urandom_range(0, 15) * 4 + 2);
            else
                a = 32'($urandom_range(0, 15) * 4);
            n  = $urandom_range(1, 6);
            bu = 2'($urandom_range(0, 3));
            for (int i = 0; i < n; i++) begin
                wdat[i] = $urandom;
                wstb[i] = 4'($urandom_range(0, 15));
            end
            do_write(4'($urandom_range(0, 15)), a, bu, n);
            do_read(4'($urandom_range(0, 15)), a, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 5), $urandom_range(0, 2));
        end

        aw_id = 4'h9; aw_addr = 32'h0; aw_len = 8'd3; aw_burst = 2'b01;
        aw_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0;
        w_data = 32'h12345678; w_strb = 4'hF; w_valid = 1'b1;
        @(negedge clk);
        w_data = 32'h9ABCDEF0;
        rst = 1'b1;
        #1;
        check_zero_outputs("mid");
        w_valid = 1'b0;
        @(negedge clk);
        check_zero_outputs("mid2");
        for (int i = 0; i < REG_NUM; i++) mdl[i] = '0;
        rst = 1'b0;
        @(negedge clk);
        wdat[0] = 32'hCAFEF00D; wstb[0] = 4'hF;
        do_write(4'hB, 32'h10, 2'b01, 1);
        do_read(4'hC, 32'h10, 2'b01, 0, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
